rf_writeback: RTL and testbench

- Write-side companion to the 8x16 register file: collects results from the ALU, data memory and PC+1, buffers them, and drives the register-file write port one write per cycle.
- Keeps a per-register busy scoreboard, set at issue and cleared at commit, and tells issue logic when to stall on RAW/WAW hazards.
- Sits between the execute/memory stages and the register file in the RiSC-16 datapath.

---
 rtl/rf_pkg.sv | 25 ++
 rtl/wb_fifo.sv | 58 +++++
 rtl/rf_writeback.sv | 134 +++++++++++++
 tb/tb_rf_writeback.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared constants for the RiSC-16 register-file writeback slice.
//   DATA_W / NREG        : datapath width and architectural register count
//   OP_*                 : RiSC-16 opcode field encodings
//   WB_*                 : writeback source-select encodings (wb_sel)
package rf_pkg;

   localparam int DATA_W = 16;
   localparam int NREG   = 8;
   localparam int RA_W   = $clog2(NREG);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_ADDI = 3'b001;
   localparam logic [2:0] OP_NAND = 3'b010;
   localparam logic [2:0] OP_LUI  = 3'b011;
   localparam logic [2:0] OP_SW   = 3'b100;
   localparam logic [2:0] OP_LW   = 3'b101;
   localparam logic [2:0] OP_BEQ  = 3'b110;
   localparam logic [2:0] OP_JALR = 3'b111;

   localparam logic [1:0] WB_MEM = 2'b00;
   localparam logic [1:0] WB_ALU = 2'b01;
   localparam logic [1:0] WB_PC1 = 2'b10;
   localparam logic [1:0] WB_ILL = 2'b11;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO, power-of-two depth, no same-cycle pass-through.
//   clk, rst        : clock, synchronous active-high reset (empties the FIFO)
//   push, push_data : write request (ignored when full)
//   pop             : read request (ignored when empty), head advances at the edge
//   head            : current oldest entry
//   full, empty     : occupancy flags, reflecting state before this cycle's push/pop
module wb_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   // Storage array: data only, never reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PW+1)'(1);
            2'b01:   count <= count - (PW+1)'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/rf_writeback.sv
// rf_writeback: buffers ALU / memory / PC+1 results and drives the register
// file write port one write per cycle, with a per-register busy scoreboard.
//   issue_*          : decode-side instruction; issue_stall flags RAW/WAW hazards
//   wb_valid/wb_ready: result handshake; wb_sel picks mem_out, alu_out or pc+1
//   rf_port_free     : write port available this cycle
//   rf_we/waddr/wdata: registered register-file write port
//   busy             : scoreboard, set at issue, cleared at commit
//   wb_err           : one-cycle pulse after an illegal wb_sel was offered
module rf_writeback
   import rf_pkg::*;
#(
   parameter int  DATA_W   = rf_pkg::DATA_W,
   parameter int  NREG     = rf_pkg::NREG,
   parameter int  WB_DEPTH = 2,
   localparam int AW       = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              issue_valid,
   input  logic              issue_we,
   input  logic [AW-1:0]     issue_rd,
   input  logic              issue_rs1_used,
   input  logic [AW-1:0]     issue_rs1,
   input  logic              issue_rs2_used,
   input  logic [AW-1:0]     issue_rs2,
   output logic              issue_stall,
   input  logic              wb_valid,
   output logic              wb_ready,
   input  logic [AW-1:0]     wb_rd,
   input  logic [1:0]        wb_sel,
   input  logic [DATA_W-1:0] mem_out,
   input  logic [DATA_W-1:0] alu_out,
   input  logic [DATA_W-1:0] pc,
   input  logic              rf_port_free,
   output logic              rf_we,
   output logic [AW-1:0]     rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic [NREG-1:0]   busy,
   output logic              wb_err
);

   localparam int EW = AW + DATA_W;

   // PC+1 wraps modulo 2^DATA_W (0xFFFF -> 0x0000).
   function automatic logic [DATA_W-1:0] wrap_inc(input logic [DATA_W-1:0] v);
      return v + DATA_W'(1);
   endfunction

   function automatic logic [DATA_W-1:0] wb_mux(input logic [1:0]        sel,
                                                input logic [DATA_W-1:0] m,
                                                input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] p);
      case (sel)
         WB_MEM:  return m;
         WB_ALU:  return a;
         default: return wrap_inc(p);
      endcase
   endfunction

   logic              fifo_full;
   logic              fifo_empty;
   logic              sel_ill_p0;
   logic              push_p0;
   logic              pop_p0;
   logic [EW-1:0]     head_p0;
   logic [AW-1:0]     head_rd_p0;
   logic [DATA_W-1:0] head_data_p0;
   logic [NREG-1:0]   busy_set;
   logic [NREG-1:0]   busy_clr;

   // Stage p0: source mux and FIFO push; illegal selects are dropped.
   assign wb_ready   = !fifo_full;
   assign sel_ill_p0 = (wb_sel == WB_ILL);
   assign push_p0    = wb_valid && !fifo_full && !sel_ill_p0;
   assign pop_p0     = !fifo_empty && rf_port_free;

   wb_fifo #(
      .WIDTH (EW),
      .DEPTH (WB_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_p0),
      .push_data ({wb_rd, wb_mux(wb_sel, mem_out, alu_out, pc)}),
      .pop       (pop_p0),
      .head      (head_p0),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign head_rd_p0   = head_p0[EW-1:DATA_W];
   assign head_data_p0 = head_p0[DATA_W-1:0];

   // Stage p1: registered write port. r0 writes drain through with rf_we low.
   always_ff @(posedge clk) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
         wb_err   <= 1'b0;
      end else begin
         rf_we  <= pop_p0 && (head_rd_p0 != '0);
         wb_err <= wb_valid && !fifo_full && sel_ill_p0;
         if (pop_p0) begin
            rf_waddr <= head_rd_p0;
            rf_wdata <= head_data_p0;
         end
      end
   end

   // Hazard check uses the current busy bits, so a same-cycle commit does not unstall.
   always_comb begin
      issue_stall = issue_valid &&
                    ((issue_we       && busy[issue_rd])  ||
                     (issue_rs1_used && busy[issue_rs1]) ||
                     (issue_rs2_used && busy[issue_rs2]));
   end

   always_comb begin
      busy_set = '0;
      busy_clr = '0;
      if (issue_valid && !issue_stall && issue_we && (issue_rd != '0))
         busy_set[issue_rd] = 1'b1;
      if (rf_we)
         busy_clr[rf_waddr] = 1'b1;
   end

   // Scoreboard: clear at the commit edge (rf_we high), set at issue.
   always_ff @(posedge clk) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~busy_clr) | busy_set;
   end

endmodule

// File: tb/tb_rf_writeback.sv
module tb_rf_writeback;
   import rf_pkg::*;

   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid, issue_we, issue_rs1_used, issue_rs2_used;
   logic [2:0]  issue_rd, issue_rs1, issue_rs2;
   logic        issue_stall;
   logic        wb_valid, wb_ready;
   logic [2:0]  wb_rd;
   logic [1:0]  wb_sel;
   logic [15:0] mem_out, alu_out, pc;
   logic        rf_port_free;
   logic        rf_we;
   logic [2:0]  rf_waddr;
   logic [15:0] rf_wdata;
   logic [7:0]  busy;
   logic        wb_err;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   rf_writeback #(.DATA_W(16), .NREG(8), .WB_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .issue_valid(issue_valid), .issue_we(issue_we), .issue_rd(issue_rd),
      .issue_rs1_used(issue_rs1_used), .issue_rs1(issue_rs1),
      .issue_rs2_used(issue_rs2_used), .issue_rs2(issue_rs2),
      .issue_stall(issue_stall),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_sel(wb_sel),
      .mem_out(mem_out), .alu_out(alu_out), .pc(pc),
      .rf_port_free(rf_port_free),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .busy(busy), .wb_err(wb_err)
   );

   // Reference model: queue of pending results plus expected register state.
   typedef struct packed { logic [2:0] rd; logic [15:0] data; } ent_t;
   ent_t        q[$];
   bit          m_we;
   logic [2:0]  m_waddr;
   logic [15:0] m_wdata;
   bit [7:0]    m_busy;
   bit          m_err;

   function automatic bit m_ready();
      return q.size() < DEPTH;
   endfunction

   function automatic bit m_stall();
      return issue_valid && ((issue_we && m_busy[issue_rd]) ||
                             (issue_rs1_used && m_busy[issue_rs1]) ||
                             (issue_rs2_used && m_busy[issue_rs2]));
   endfunction

   task automatic idle();
      rst = 0; issue_valid = 0; issue_we = 0; issue_rd = 0;
      issue_rs1_used = 0; issue_rs1 = 0; issue_rs2_used = 0; issue_rs2 = 0;
      wb_valid = 0; wb_rd = 0; wb_sel = WB_ALU; mem_out = 0; alu_out = 0; pc = 0;
      rf_port_free = 1;
   endtask

   // Advance the model across one rising edge with the present inputs.
   task automatic tick();
      bit ready, stall, accept;
      bit [7:0] nb;
      ent_t e;
      logic [15:0] d;
      ready = m_ready();
      stall = m_stall();
      if (rst) begin
         q.delete(); m_we = 0; m_waddr = 0; m_wdata = 0; m_busy = 0; m_err = 0;
      end else begin
         nb = m_busy;
         if (m_we) nb[m_waddr] = 0;
         if (issue_valid && !stall && issue_we && issue_rd != 0) nb[issue_rd] = 1;
         accept = wb_valid && ready;
         m_err = accept && (wb_sel == 2'b11);
         m_we = 0;
         if (q.size() > 0 && rf_port_free) begin
            e = q.pop_front();
            m_we = (e.rd != 0); m_waddr = e.rd; m_wdata = e.data;
         end
         if (accept && wb_sel != 2'b11) begin
            d = (wb_sel == 2'b00) ? mem_out : (wb_sel == 2'b01) ? alu_out : pc + 16'd1;
            e.rd = wb_rd; e.data = d;
            q.push_back(e);
         end
         m_busy = nb;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle(); rst = 1; tick(); rst = 0; #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL reset_rf_we got=%0b exp=0", rf_we); end
      checks++; if (rf_waddr !== 3'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
      checks++; if (rf_wdata !== 16'h0) begin failures++; $display("FAIL reset_wdata got=%h exp=0000", rf_wdata); end
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL reset_busy got=%h exp=00", busy); end
      checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL reset_wb_err got=%0b exp=0", wb_err); end
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL reset_wb_ready got=%0b exp=1", wb_ready); end
   endtask

   task automatic test_alu_write();
      idle(); issue_valid = 1; issue_we = 1; issue_rd = 3; #1;
      checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL alu_issue_stall got=%0b exp=0", issue_stall); end
      tick();
      idle(); wb_valid = 1; wb_sel = WB_ALU; alu_out = 16'h1234; wb_rd = 3; #1;
      checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL alu_busy_set got=%0b exp=1", busy[3]); end
      tick();
      idle(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_we_early got=%0b exp=0", rf_we); end
      tick(); #1;
      checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL alu_we got=%0b exp=1", rf_we); end
      checks++; if (rf_waddr !== 3'd3) begin failures++; $display("FAIL alu_waddr got=%0d exp=3", rf_waddr); end
      checks++; if (rf_wdata !== 16'h1234) begin failures++; $display("FAIL alu_wdata got=%h exp=1234", rf_wdata); end
      checks++; if (busy[3] !== 1'b1) begin failures++; $display("FAIL alu_busy_hold got=%0b exp=1", busy[3]); end
      tick(); #1;
      checks++; if (busy[3] !== 1'b0) begin failures++; $display("FAIL alu_busy_clr got=%0b exp=0", busy[3]); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL alu_we_drop got=%0b exp=0", rf_we); end
   endtask

   task automatic test_pc_wrap_illegal();
      idle(); wb_valid = 1; wb_sel = WB_PC1; pc = 16'hFFFF; wb_rd = 7; tick();
      idle(); tick(); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd7) begin failures++; $display("FAIL pc1_we_addr got=%0b/%0d exp=1/7", rf_we, rf_waddr); end
      checks++; if (rf_wdata !== 16'h0000) begin failures++; $display("FAIL pc1_wrap got=%h exp=0000", rf_wdata); end
      tick();
      idle(); wb_valid = 1; wb_sel = WB_ILL; wb_rd = 6; alu_out = 16'hAAAA; mem_out = 16'h5555; #1;
      checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL ill_err_early got=%0b exp=0", wb_err); end
      tick();
      idle(); #1;
      checks++; if (wb_err !== 1'b1) begin failures++; $display("FAIL ill_err_pulse got=%0b exp=1", wb_err); end
      tick(); #1;
      checks++; if (wb_err !== 1'b0) begin failures++; $display("FAIL ill_err_once got=%0b exp=0", wb_err); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ill_no_write got=%0b exp=0", rf_we); end
      tick(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ill_no_write_late got=%0b exp=0", rf_we); end
   endtask

   task automatic test_fill_drain();
      idle(); rf_port_free = 0; wb_valid = 1; wb_rd = 1; alu_out = 16'h1111; #1;
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL fill_ready1 got=%0b exp=1", wb_ready); end
      tick();
      wb_rd = 2; alu_out = 16'h2222; #1;
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL fill_ready2 got=%0b exp=1", wb_ready); end
      tick();
      wb_rd = 4; alu_out = 16'h4444; #1;
      checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL fill_full got=%0b exp=0", wb_ready); end
      tick();
      rf_port_free = 1; #1;
      checks++; if (wb_ready !== 1'b0) begin failures++; $display("FAIL fill_no_passthru got=%0b exp=0", wb_ready); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL fill_held got=%0b exp=0", rf_we); end
      tick(); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd1 || rf_wdata !== 16'h1111) begin failures++; $display("FAIL drain_first got=%0b/%0d/%h exp=1/1/1111", rf_we, rf_waddr, rf_wdata); end
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL drain_ready got=%0b exp=1", wb_ready); end
      tick();
      idle(); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd2 || rf_wdata !== 16'h2222) begin failures++; $display("FAIL drain_second got=%0b/%0d/%h exp=1/2/2222", rf_we, rf_waddr, rf_wdata); end
      tick(); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd4 || rf_wdata !== 16'h4444) begin failures++; $display("FAIL drain_third got=%0b/%0d/%h exp=1/4/4444", rf_we, rf_waddr, rf_wdata); end
      tick(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL drain_done got=%0b exp=0", rf_we); end
   endtask

   task automatic test_stall();
      idle(); issue_valid = 1; issue_we = 1; issue_rd = 5; #1;
      checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL stall_first_issue got=%0b exp=0", issue_stall); end
      tick();
      idle(); issue_valid = 1; issue_rs1_used = 1; issue_rs1 = 5;
      wb_valid = 1; wb_sel = WB_ALU; wb_rd = 5; alu_out = 16'h5555; #1;
      checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL stall_raw_a got=%0b exp=1", issue_stall); end
      tick();
      wb_valid = 0; #1;
      checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL stall_raw_b got=%0b exp=1", issue_stall); end
      tick(); #1;
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 3'd5) begin failures++; $display("FAIL stall_commit got=%0b/%0d exp=1/5", rf_we, rf_waddr); end
      checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL stall_same_cycle got=%0b exp=1", issue_stall); end
      issue_rs1_used = 0; issue_we = 1; issue_rd = 5; #1;
      checks++; if (issue_stall !== 1'b1) begin failures++; $display("FAIL stall_waw got=%0b exp=1", issue_stall); end
      tick();
      issue_we = 0; issue_rs1_used = 1; issue_rs1 = 5; #1;
      checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL stall_release got=%0b exp=0", issue_stall); end
      checks++; if (busy[5] !== 1'b0) begin failures++; $display("FAIL stall_busy5 got=%0b exp=0", busy[5]); end
      tick();
   endtask

   task automatic test_r0();
      idle(); issue_valid = 1; issue_we = 1; issue_rd = 0; #1;
      checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL r0_issue_stall got=%0b exp=0", issue_stall); end
      tick(); #1;
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL r0_busy got=%h exp=00", busy); end
      idle(); wb_valid = 1; wb_sel = WB_MEM; wb_rd = 0; mem_out = 16'hBEEF; tick();
      idle(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_we_a got=%0b exp=0", rf_we); end
      tick();
      issue_valid = 1; issue_rs1_used = 1; issue_rs1 = 0; issue_rs2_used = 1; issue_rs2 = 0; #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL r0_we_b got=%0b exp=0", rf_we); end
      checks++; if (issue_stall !== 1'b0) begin failures++; $display("FAIL r0_src_stall got=%0b exp=0", issue_stall); end
      tick(); #1;
      checks++; if (rf_we !== 1'b0 || busy !== 8'h00) begin failures++; $display("FAIL r0_after got=%0b/%h exp=0/00", rf_we, busy); end
   endtask

   task automatic test_reset_mid();
      idle(); rf_port_free = 0; issue_valid = 1; issue_we = 1; issue_rd = 2; tick();
      idle(); rf_port_free = 0; wb_valid = 1; wb_rd = 1; alu_out = 16'h0101; tick();
      wb_rd = 3; alu_out = 16'h0303; tick();
      idle(); rf_port_free = 0; #1;
      checks++; if (wb_ready !== 1'b0 || busy[2] !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0b/%0b exp=0/1", wb_ready, busy[2]); end
      rst = 1; tick(); rst = 0; rf_port_free = 1; #1;
      checks++; if (wb_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%0b exp=1", wb_ready); end
      checks++; if (busy !== 8'h00) begin failures++; $display("FAIL mid_busy got=%h exp=00", busy); end
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_we got=%0b exp=0", rf_we); end
      tick(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_discard_a got=%0b exp=0", rf_we); end
      tick(); #1;
      checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL mid_discard_b got=%0b exp=0", rf_we); end
   endtask

   task automatic test_random();
      for (int n = 0; n < 600; n++) begin
         rst            = ($urandom % 97) == 0;
         issue_valid    = $urandom % 2;
         issue_we       = $urandom % 2;
         issue_rd       = 3'($urandom);
         issue_rs1_used = $urandom % 2;
         issue_rs1      = 3'($urandom);
         issue_rs2_used = $urandom % 2;
         issue_rs2      = 3'($urandom);
         wb_valid       = ($urandom % 3) != 0;
         wb_rd          = 3'($urandom);
         wb_sel         = (($urandom % 8) == 0) ? 2'b11 : 2'($urandom % 3);
         mem_out        = 16'($urandom);
         alu_out        = 16'($urandom);
         pc             = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom);
         rf_port_free   = ($urandom % 4) != 0;
         #1;
         checks++; if (wb_ready !== m_ready()) begin failures++; $display("FAIL rnd_ready n=%0d got=%0b exp=%0b", n, wb_ready, m_ready()); end
         checks++; if (issue_stall !== m_stall()) begin failures++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, issue_stall, m_stall()); end
         checks++; if (rf_we !== m_we) begin failures++; $display("FAIL rnd_we n=%0d got=%0b exp=%0b", n, rf_we, m_we); end
         checks++; if (rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin failures++; $display("FAIL rnd_port n=%0d got=%0d/%h exp=%0d/%h", n, rf_waddr, rf_wdata, m_waddr, m_wdata); end
         checks++; if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy, m_busy); end
         checks++; if (wb_err !== m_err) begin failures++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, wb_err, m_err); end
         tick();
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      idle();
      @(negedge clk);
      test_reset();
      test_alu_write();
      test_pc_wrap_illegal();
      test_fill_drain();
      test_stall();
      test_r0();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
